// File: rtl/cam_loader_pkg.sv
// Shared types and helpers for the CAM boot loader: FSM state encoding,
// erased-word pattern and loaded-count width.
package cam_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAM_RST,
    REQ,
    WAIT,
    WRITE,
    NEXT,
    DONE,
    ERR
  } loader_state_e;

  localparam int MAX_DATA_W = 64;

  // Erased flash reads back as all ones in the low `width` bits.
  function automatic logic [MAX_DATA_W-1:0] ERASED_WORD(input int width);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) w[i] = 1'b1;
    end
    return w;
  endfunction

  function automatic int LOADED_W(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/busy_timeout_ctr.sv
// Per-word flash busy watchdog: reloads on clear, counts down while enabled,
// flags the enabled cycle that uses up the last of TIMEOUT busy cycles.
module busy_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(TIMEOUT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cam_boot_loader.sv
// Boot-time copy of DEPTH password words from flash into the CAM, with CAM
// reset sequencing, busy handshake, erased-word skip and busy timeout abort.
//
// state   | meaning
// IDLE    | CAM held in reset, waiting for a boot rising edge
// CAM_RST | CAM reset held for RST_CYC cycles
// REQ     | one-cycle flash read strobe for addr
// WAIT    | waiting for flash_busy low, watchdog running
// WRITE   | one-cycle CAM write of captured word
// NEXT    | advance address or finish
// DONE    | load complete, hold while boot stays high
// ERR     | busy timeout, hold while boot stays high
module cam_boot_loader
  import cam_loader_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int RST_CYC     = 3,
  parameter int TIMEOUT     = 255,
  parameter int SKIP_ERASED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot,
  input  logic              flash_busy,
  input  logic [DATA_W-1:0] flash_data,
  output logic              flash_rd,
  output logic [ADDR_W-1:0] addr_out,
  output logic              flash_to_cam,
  output logic              cam_rst,
  output logic              cam_we,
  output logic [DATA_W-1:0] cam_data,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_cnt
);

  localparam int LW   = LOADED_W(ADDR_W);
  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam logic [DATA_W-1:0] ERASED = DATA_W'(ERASED_WORD(DATA_W));
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_e     state_q, state_d;
  logic              boot_q, boot_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     loaded_q, loaded_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flash_rd_q, flash_rd_d;
  logic              cam_we_q, cam_we_d;
  logic              cam_rst_q, cam_rst_d;
  logic              f2c_q, f2c_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic tmo_clear, tmo_en, tmo_expired;

  assign tmo_clear = (state_q == REQ);
  assign tmo_en    = (state_q == WAIT) && flash_busy;

  busy_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    boot_d     = boot;
    rst_cnt_d  = rst_cnt_q;
    addr_d     = addr_q;
    loaded_d   = loaded_q;
    data_d     = data_q;
    flash_rd_d = 1'b0;
    cam_we_d   = 1'b0;
    cam_rst_d  = cam_rst_q;
    f2c_d      = f2c_q;
    done_d     = done_q;
    error_d    = error_q;

    if (!boot) begin
      // Dropping boot abandons whatever is in flight.
      state_d   = IDLE;
      cam_rst_d = 1'b1;
      f2c_d     = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!boot_q) begin
            state_d   = CAM_RST;
            addr_d    = '0;
            loaded_d  = '0;
            done_d    = 1'b0;
            error_d   = 1'b0;
            cam_rst_d = 1'b1;
            f2c_d     = 1'b1;
            rst_cnt_d = RC_W'(RST_CYC);
          end
        end
        CAM_RST: begin
          if (rst_cnt_q == RC_W'(1)) begin
            state_d    = REQ;
            cam_rst_d  = 1'b0;
            flash_rd_d = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
          end
        end
        REQ: state_d = WAIT;
        WAIT: begin
          if (!flash_busy) begin
            data_d = flash_data;
            if ((SKIP_ERASED != 0) && (flash_data == ERASED)) begin
              state_d = NEXT;
            end else begin
              state_d  = WRITE;
              cam_we_d = 1'b1;
            end
          end else if (tmo_expired) begin
            state_d   = ERR;
            error_d   = 1'b1;
            f2c_d     = 1'b0;
            cam_rst_d = 1'b0;
          end
        end
        WRITE: begin
          state_d  = NEXT;
          loaded_d = loaded_q + 1'b1;
        end
        NEXT: begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
            f2c_d   = 1'b0;
          end else begin
            state_d    = REQ;
            addr_d     = addr_q + 1'b1;
            flash_rd_d = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      boot_q     <= boot;
      rst_cnt_q  <= '0;
      addr_q     <= '0;
      loaded_q   <= '0;
      data_q     <= '0;
      flash_rd_q <= 1'b0;
      cam_we_q   <= 1'b0;
      cam_rst_q  <= 1'b1;
      f2c_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_q     <= boot_d;
      rst_cnt_q  <= rst_cnt_d;
      addr_q     <= addr_d;
      loaded_q   <= loaded_d;
      data_q     <= data_d;
      flash_rd_q <= flash_rd_d;
      cam_we_q   <= cam_we_d;
      cam_rst_q  <= cam_rst_d;
      f2c_q      <= f2c_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign flash_rd     = flash_rd_q;
  assign addr_out     = addr_q;
  assign flash_to_cam = f2c_q;
  assign cam_rst      = cam_rst_q;
  assign cam_we       = cam_we_q;
  assign cam_data     = data_q;
  assign done         = done_q;
  assign error        = error_q;
  assign loaded_cnt   = loaded_q;

endmodule

// File: tb/tb_cam_boot_loader.sv
// Directed bench for cam_boot_loader: a queue-based write model plus
// per-word cycle arithmetic, checked every cycle a CAM write occurs.
module tb_cam_boot_loader;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int RST_CYC = 3;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              boot;
  logic              flash_busy;
  logic [DATA_W-1:0] flash_data;
  logic              flash_rd;
  logic [ADDR_W-1:0] addr_out;
  logic              flash_to_cam;
  logic              cam_rst;
  logic              cam_we;
  logic [DATA_W-1:0] cam_data;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   loaded_cnt;

  always #5 clk = ~clk;

  cam_boot_loader #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .RST_CYC     (RST_CYC),
    .TIMEOUT     (TIMEOUT),
    .SKIP_ERASED (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .boot         (boot),
    .flash_busy   (flash_busy),
    .flash_data   (flash_data),
    .flash_rd     (flash_rd),
    .addr_out     (addr_out),
    .flash_to_cam (flash_to_cam),
    .cam_rst      (cam_rst),
    .cam_we       (cam_we),
    .cam_data     (cam_data),
    .done         (done),
    .error        (error),
    .loaded_cnt   (loaded_cnt)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [DATA_W-1:0] mem [DEPTH];
  assign flash_data = mem[addr_out];

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  rd_cnt = 0;
  int  we_cnt = 0;
  int  first_rd = -1;
  int  stall_n = 0;
  int  stall_left = 0;
  int  stuck_addr = -1;
  bit  we_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Flash busy model: stall_n busy WAIT cycles after each read, or stuck busy at one address.
  always @(posedge clk) begin
    #1;
    if (stuck_addr >= 0 && int'(addr_out) == stuck_addr) begin
      flash_busy = 1'b1;
    end else if (flash_rd) begin
      stall_left = stall_n + 1;
      flash_busy = 1'b1;
    end else if (stall_left > 0) begin
      stall_left--;
      flash_busy = (stall_left > 0);
    end else begin
      flash_busy = 1'b0;
    end
  end

  // Compare process: every CAM write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (flash_rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc - t0;
    end
    if (cam_we) begin
      we_cnt++;
      chk("we_single_pulse", 32'(we_prev), 32'd0);
      chk("we_cam_rst_low", 32'(cam_rst), 32'd0);
      chk("we_flash_to_cam", 32'(flash_to_cam), 32'd1);
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 32'(cam_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("we_addr", 32'(addr_out), 32'(e.a));
        chk("we_data", 32'(cam_data), 32'(e.d));
      end
    end
    we_prev = cam_we;
  end

  task automatic fill_mem();
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(16'h0100 + a);
  endtask

  // Builds the expected write list and the edge-to-done cycle count.
  task automatic start_load(input int stall, output int exp_cycles);
    wr_t w;
    exp_q.delete();
    exp_cycles = RST_CYC + 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] == 16'hFFFF) begin
        exp_cycles += 3 + stall;
      end else begin
        w.a = 8'(a);
        w.d = mem[a];
        exp_q.push_back(w);
        exp_cycles += 4 + stall;
      end
    end
    stall_n  = stall;
    first_rd = -1;
    @(posedge clk);
    #1;
    boot = 1'b1;
    t0 = cyc;
    rd_cnt = 0;
    we_cnt = 0;
  endtask

  task automatic wait_end(output int n);
    n = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done || error) begin
        n = cyc - t0;
        break;
      end
    end
    chk("end_reached", 32'(done | error), 32'd1);
  endtask

  task automatic stop_boot();
    boot = 1'b0;
    @(negedge clk);
    chk("idle_cam_rst", 32'(cam_rst), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_error", 32'(error), 32'd0);
    chk("idle_f2c", 32'(flash_to_cam), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int exp_n;
    int n;
    int snap_we;
    int snap_rd;
    bit found;

    rst = 1'b1;
    boot = 1'b0;
    flash_busy = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cam_rst", 32'(cam_rst), 32'd1);
    chk("rst_flash_rd", 32'(flash_rd), 32'd0);
    chk("rst_cam_we", 32'(cam_we), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_f2c", 32'(flash_to_cam), 32'd0);
    chk("rst_data", 32'(cam_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_loaded", 32'(loaded_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full load, no stalls.
    start_load(0, exp_n);
    wait_end(n);
    chk("full_first_rd", 32'(first_rd), 32'd4);
    chk("full_done_lit", 32'(n), 32'd68);
    chk("full_done_model", 32'(n), 32'(exp_n));
    chk("full_loaded", 32'(loaded_cnt), 32'd16);
    chk("full_we_cnt", 32'(we_cnt), 32'd16);
    chk("full_writes_left", 32'(exp_q.size()), 32'd0);
    chk("full_error", 32'(error), 32'd0);
    chk("full_f2c", 32'(flash_to_cam), 32'd0);
    stop_boot();

    // Erased words 3 and 7 are skipped.
    mem[3] = 16'hFFFF;
    mem[7] = 16'hFFFF;
    start_load(0, exp_n);
    wait_end(n);
    chk("skip_done_lit", 32'(n), 32'd66);
    chk("skip_done_model", 32'(n), 32'(exp_n));
    chk("skip_done", 32'(done), 32'd1);
    chk("skip_loaded", 32'(loaded_cnt), 32'd14);
    chk("skip_writes_left", 32'(exp_q.size()), 32'd0);
    stop_boot();

    // Five busy cycles after every read.
    fill_mem();
    start_load(5, exp_n);
    wait_end(n);
    chk("stall_first_rd", 32'(first_rd), 32'd4);
    chk("stall_done_lit", 32'(n), 32'd148);
    chk("stall_done_model", 32'(n), 32'(exp_n));
    chk("stall_loaded", 32'(loaded_cnt), 32'd16);
    chk("stall_writes_left", 32'(exp_q.size()), 32'd0);
    stop_boot();

    // Busy stuck at address 2: abort after TIMEOUT wait cycles.
    stuck_addr = 2;
    start_load(0, exp_n);
    wait_end(n);
    chk("tmo_err_lit", 32'(n), 32'd21);
    chk("tmo_err_model", 32'(n), 32'(RST_CYC + 1 + 2 * 4 + 1 + TIMEOUT));
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    chk("tmo_loaded", 32'(loaded_cnt), 32'd2);
    chk("tmo_f2c", 32'(flash_to_cam), 32'd0);
    chk("tmo_cam_rst", 32'(cam_rst), 32'd0);
    snap_rd = rd_cnt;
    repeat (20) @(negedge clk);
    chk("tmo_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("tmo_no_more_rd", 32'(rd_cnt), 32'(snap_rd));
    chk("tmo_error_held", 32'(error), 32'd1);
    stuck_addr = -1;
    exp_q.delete();
    stop_boot();

    // Boot dropped while reading address 5, then restarted.
    start_load(0, exp_n);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flash_rd && addr_out == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("drop_reached_addr5", 32'(found), 32'd1);
    boot = 1'b0;
    @(negedge clk);
    chk("drop_cam_rst", 32'(cam_rst), 32'd1);
    chk("drop_done", 32'(done), 32'd0);
    chk("drop_f2c", 32'(flash_to_cam), 32'd0);
    chk("drop_we_cnt", 32'(we_cnt), 32'd5);
    exp_q.delete();
    repeat (2) @(negedge clk);
    start_load(0, exp_n);
    wait_end(n);
    chk("restart_done", 32'(n), 32'd68);
    chk("restart_loaded", 32'(loaded_cnt), 32'd16);
    chk("restart_writes_left", 32'(exp_q.size()), 32'd0);
    stop_boot();

    // Reset during a write cycle.
    start_load(0, exp_n);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cam_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstw_reached_we", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_cam_rst", 32'(cam_rst), 32'd1);
    chk("rstw_cam_we", 32'(cam_we), 32'd0);
    chk("rstw_flash_rd", 32'(flash_rd), 32'd0);
    chk("rstw_addr", 32'(addr_out), 32'd0);
    chk("rstw_f2c", 32'(flash_to_cam), 32'd0);
    chk("rstw_data", 32'(cam_data), 32'd0);
    chk("rstw_loaded", 32'(loaded_cnt), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    snap_we = we_cnt;
    snap_rd = rd_cnt;
    repeat (20) @(negedge clk);
    chk("rstw_no_second_we", 32'(we_cnt), 32'(snap_we));
    chk("rstw_no_restart_rd", 32'(rd_cnt), 32'(snap_rd));
    chk("rstw_cam_rst_held", 32'(cam_rst), 32'd1);
    boot = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_boot_loader.md
# cam_boot_loader

Parametrised boot-time loader that copies DEPTH stored-password words from the external flash into the CAM. It sequences CAM reset, per-word flash reads gated by the flash `busy` handshake, and single-cycle CAM write pulses. It can skip erased (all-ones) flash words and aborts on a busy timeout. It sits between the top-level boot control and the flash/CAM pair, and owns the shared address bus during load.

## Interface
- `DATA_W`, default 16: width of flash and CAM data words.
- `ADDR_W`, default 4: width of the shared flash/CAM address.
- `DEPTH`, default 16: number of words to load; 1 ≤ DEPTH ≤ 2^ADDR_W.
- `RST_CYC`, default 3: number of cycles `cam_rst` is held high at load start; must be ≥ 1.
- `TIMEOUT`, default 255: maximum number of WAIT cycles per word before an error is raised.
- `SKIP_ERASED`, default 1: when 1, all-ones flash words are not written to the CAM.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous active-high reset.
- `boot`, in, 1: level request; a 0→1 edge starts a load.
- `flash_busy`, in, 1: flash busy; data is valid in the first sampled cycle where it is 0.
- `flash_data`, in, DATA_W: flash read data.
- `flash_rd`, out, 1: one-cycle read strobe.
- `addr_out`, out, ADDR_W: shared flash/CAM address.
- `flash_to_cam`, out, 1: data mux select; high from CAM_RST through the last WRITE.
- `cam_rst`, out, 1: CAM reset.
- `cam_we`, out, 1: one-cycle CAM write pulse.
- `cam_data`, out, DATA_W: registered write data.
- `done`, out, 1: load complete.
- `error`, out, 1: load aborted by busy timeout.
- `loaded_cnt`, out, ADDR_W+1: number of CAM writes performed.

## Operation
- Reset values: state IDLE, `cam_rst`=1, and every other output 0.
- IDLE: `cam_rst`=1. A `boot` rising edge (registered `boot` was 0, current is 1) clears `addr`, `loaded_cnt`, `done` and `error`, then enters CAM_RST.
- CAM_RST: `cam_rst`=1 for RST_CYC cycles, then enters REQ with `cam_rst`=0.
- REQ: `flash_rd`=1 for one cycle, then enters WAIT and clears the timeout counter.
- WAIT: samples `flash_busy` every cycle starting the cycle after REQ.
  - Busy=0: capture `flash_data` into `cam_data`, then go to WRITE, or to NEXT if SKIP_ERASED=1 and the data is all ones.
  - Busy=1: increment the timeout counter. When the counter reaches TIMEOUT, set `error`=1 and go to ERR.
- WRITE: `cam_we`=1 for one cycle, `loaded_cnt`++, then NEXT.
- NEXT: if `addr`==DEPTH-1, go to DONE; otherwise `addr`++ and go to REQ. The address never wraps.
- DONE: `done`=1, `flash_to_cam`=0. Stays here while `boot`=1.
- ERR: `error`=1, `flash_to_cam`=0, `cam_rst`=0. Stays here while `boot`=1.
- `boot`=0 in any state: return to IDLE at the next edge. A partial load is abandoned, `done` and `error` are cleared, and `cam_rst` is reasserted.
- `rst` overrides everything on the same edge, including during a write.
- If `boot` rises in the same cycle `rst` is high, the edge is ignored; the registered `boot` takes the current value.

## Timing
- Boot edge to first `flash_rd`: RST_CYC+1 cycles (the edge cycle plus RST_CYC cycles of CAM_RST).
- Per-word cycle with busy always 0: REQ, WAIT, WRITE, NEXT, i.e. 4 cycles.
- A skipped word takes 3 cycles.
- `cam_data` and `addr_out` are stable during the `cam_we` cycle; `addr_out` changes only in NEXT.
- `done` rises in the cycle after the final NEXT.
- Full load with no busy stalls: RST_CYC + 1 + 4·DEPTH cycles from the edge to `done`.

## Structure
- Shared package `cam_loader_pkg` contains:
  - the state enum: IDLE, CAM_RST, REQ, WAIT, WRITE, NEXT, DONE, ERR;
  - the `ERASED_WORD` all-ones constant function;
  - `LOADED_W` = ADDR_W+1.
- One sub-module, `busy_timeout_ctr` (clear, enable, expired flag), is parametrised on TIMEOUT.
- Everything else lives in the single FSM module.

## Test plan
- Defaults, busy held 0, flash returns `addr+0x100`:
  - 16 `cam_we` pulses at addresses 0..15 with data 0x100..0x10F;
  - `done`=1 exactly 68 cycles after the boot edge;
  - `loaded_cnt`=16.
- SKIP_ERASED=1 with words 3 and 7 = 0xFFFF: no `cam_we` at addresses 3 and 7, `loaded_cnt`=14, `done`=1.
- Busy high for 5 cycles after each REQ: every write still occurs with the correct data, and each word takes 9 cycles.
- TIMEOUT=8 with busy stuck high at address 2: `error`=1 after 8 WAIT cycles, `done`=0, `loaded_cnt`=2, no further `flash_rd`.
- `boot` dropped during address 5:
  - state returns to IDLE next cycle with `cam_rst`=1 and `done`=0;
  - re-raising `boot` restarts from address 0.
- `rst` pulsed during a WRITE cycle: all outputs reach their reset values at the next edge, and no second `cam_we` is issued.
